counter_shift_multi: RTL

Parametrised shift-register counter for the counters library. It runs as a Johnson (twisted-ring) counter or a one-hot ring counter, selected at run time, and can step in either direction. It adds a synchronous clear, decoded step index, wrap pulse and automatic recovery from illegal states. It serves as the general-purpose sequencer and phase generator wherever a glitch-free decoded count is needed.

---
 rtl/counter_shift_multi.sv | 105 ++++++++++
 1 files changed

// File: rtl/counter_shift_multi.sv
// Johnson / one-hot ring shift counter with run-time mode and direction,
// synchronous clear, decoded index, wrap pulse and illegal-state recovery.
module counter_shift_multi #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             fault
);

  logic [WIDTH-1:0] q_q, q_d, seed, step;
  logic             wrap_q, wrap_d, fault_q, fault_d;
  logic             legal, at_wrap;
  logic [IW-1:0]    idx_c;
  int               ones, trans, pos, per;

  // Johnson states have at most one 0/1 boundary; ring states exactly one set bit.
  always_comb begin
    ones  = 0;
    trans = 0;
    pos   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_q[i]) begin
        ones = ones + 1;
        pos  = i;
      end
    end
    for (int i = 0; i < WIDTH-1; i++)
      if (q_q[i] != q_q[i+1]) trans = trans + 1;
  end

  always_comb begin
    idx_c = '0;
    legal = 1'b0;
    per   = 2*WIDTH;
    seed  = '0;
    if (mode) begin
      per   = WIDTH;
      seed  = {{(WIDTH-1){1'b0}}, 1'b1};
      legal = (ones == 1);
      if (legal) idx_c = IW'(pos);
    end else begin
      legal = (trans <= 1);
      // ones in the LSBs count up from 0; zeros in the LSBs count the second half
      if (legal) begin
        if (q_q[0] || ones == 0) idx_c = IW'(ones);
        else                     idx_c = IW'(2*WIDTH - ones);
      end
    end
  end

  always_comb begin
    step = q_q;
    case ({mode, dir})
      2'b00: step = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      2'b01: step = {~q_q[0], q_q[WIDTH-1:1]};
      2'b10: step = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      2'b11: step = {q_q[0], q_q[WIDTH-1:1]};
      default: step = q_q;
    endcase
  end

  assign at_wrap = dir ? (idx_c == '0) : (idx_c == IW'(per - 1));

  always_comb begin
    q_d     = q_q;
    wrap_d  = 1'b0;
    fault_d = 1'b0;
    if (clr) begin
      q_d = seed;
    end else if (!legal) begin
      q_d     = seed;
      fault_d = 1'b1;
    end else if (en) begin
      q_d    = step;
      wrap_d = at_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
    end
  end

  assign q     = q_q;
  assign idx   = idx_c;
  assign wrap  = wrap_q;
  assign fault = fault_q;

endmodule
